rr_scheduler: RTL and testbench

RR_SCHEDULER -- requirements
Module: rr_scheduler

---
 rtl/rr_scheduler.sv | 243 ++++++++++++++++++++++++
 tb/tb_rr_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_scheduler.sv
// ---------------------------------------------------------------------------
// rr_scheduler
//
// Moves packets from an N_PORTS x N_PORTS matrix of input RAMs into
// N_PORTS output RAMs. Input RAM [j][i] carries words from source j that
// are destined for output i. A zero word marks the end of a packet.
//
// Each output runs its own small IDLE/LOCKED machine:
//   - In IDLE it picks a source with a non-empty RAM and a non-zero head
//     word. The search is round-robin, starting just after the last source
//     served.
//   - In LOCKED it stays on that source until the zero delimiter has been
//     copied. It stalls whenever the source RAM runs dry.
//
// A shared phase counter spaces the transfers READ_WAIT cycles apart. The
// RAM read data settles during those idle cycles, after the read address
// has moved.
//
// Ports:
//   clk         rising-edge clock for all state
//   reset       asynchronous, active-high; clears all state
//   enable      advances the scheduler; all state holds while low
//   inp         read data of input RAM [j][i]
//   in_wr_add   write pointer of input RAM [j][i]
//   in_rd_add   read pointer of input RAM [j][i] (owned by this block)
//   in_rden     read enable of every input RAM
//   outp        word presented to output RAM i
//   out_wr      one-cycle write strobe for output RAM i
//   busy        output i is locked to a source
//   grant_src   source currently or most recently served by output i
//   total_time  enabled cycles with any data pending (saturating)
// ---------------------------------------------------------------------------
module rr_scheduler #(
   parameter int N_PORTS   = 4,
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 12,
   parameter int READ_WAIT = 2,
   localparam int SRC_W    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [DATA_W-1:0] inp        [N_PORTS][N_PORTS],
   input  logic [ADDR_W-1:0] in_wr_add  [N_PORTS][N_PORTS],
   output logic [ADDR_W-1:0] in_rd_add  [N_PORTS][N_PORTS],
   output logic              in_rden    [N_PORTS][N_PORTS],
   output logic [DATA_W-1:0] outp       [N_PORTS],
   output logic              out_wr     [N_PORTS],
   output logic              busy       [N_PORTS],
   output logic [SRC_W-1:0]  grant_src  [N_PORTS],
   output logic [31:0]       total_time
);

   localparam int PH_W = (READ_WAIT > 0) ? $clog2(READ_WAIT + 1) : 1;

   typedef enum logic {
      IDLE,
      LOCKED
   } state_t;

   state_t              state      [N_PORTS];
   state_t              state_next [N_PORTS];

   logic [PH_W-1:0]     phase;
   logic                xfer_phase;
   logic                pending;

   logic                pick_valid [N_PORTS];
   logic [SRC_W-1:0]    pick_src   [N_PORTS];

   logic                move       [N_PORTS];
   logic [SRC_W-1:0]    move_src   [N_PORTS];
   logic [DATA_W-1:0]   move_word  [N_PORTS];

   // Only the last phase of each READ_WAIT+1 cycle window may move data.
   // An earlier move would copy RAM read data that has not yet settled
   // after the previous address change.
   assign xfer_phase = enable && (phase == PH_W'(READ_WAIT));

   // The phase counter runs 0..READ_WAIT and then wraps. It freezes with
   // enable so that a paused scheduler resumes on the same phase.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase <= '0;
      end else if (enable) begin
         if (phase == PH_W'(READ_WAIT)) begin
            phase <= '0;
         end else begin
            phase <= phase + PH_W'(1);
         end
      end
   end

   // Data counts as pending when any read pointer is strictly behind its
   // write pointer. total_time uses this to measure how long the scheduler
   // spends with work outstanding.
   always_comb begin
      pending = 1'b0;
      for (int j = 0; j < N_PORTS; j++) begin
         for (int i = 0; i < N_PORTS; i++) begin
            if (in_rd_add[j][i] < in_wr_add[j][i]) begin
               pending = 1'b1;
            end
         end
      end
   end

   // total_time sticks at all-ones rather than wrapping. A long run then
   // reads as "very long" instead of silently restarting from a small
   // number.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         total_time <= '0;
      end else if (enable && pending && (total_time != '1)) begin
         total_time <= total_time + 32'd1;
      end
   end

   // Round-robin search per output. The scan starts at grant_src+1 and
   // stops at the first source that qualifies. A source qualifies when its
   // RAM holds unread words and its head word is non-zero. A zero head
   // word is a bare delimiter, and granting it would open an empty packet.
   always_comb begin : arbitrate
      logic [SRC_W-1:0] sel;
      sel = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         pick_valid[i] = 1'b0;
         pick_src[i]   = grant_src[i];
         for (int k = 1; k <= N_PORTS; k++) begin
            sel = SRC_W'((int'(grant_src[i]) + k) % N_PORTS);
            if (!pick_valid[i] &&
                (inp[sel][i] != '0) &&
                (in_rd_add[sel][i] < in_wr_add[sel][i])) begin
               pick_valid[i] = 1'b1;
               pick_src[i]   = sel;
            end
         end
      end
   end

   // FSM state register, one machine per output. Each machine moves only
   // on a transfer phase, so enable low freezes all of them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_PORTS; i++) begin
            state[i] <= IDLE;
         end
      end else begin
         for (int i = 0; i < N_PORTS; i++) begin
            state[i] <= state_next[i];
         end
      end
   end

   // FSM output logic. This block decides whether output i moves a word
   // this cycle, and from which source.
   // - In IDLE, the arbiter's choice is used, so the first word moves in
   //   the same cycle as the grant.
   // - In LOCKED, the move happens only when the source RAM still has
   //   unread words. Inequality is used instead of less-than so that a
   //   write pointer that has wrapped past zero still counts as "data
   //   available".
   // Every input RAM is read-enabled whenever the scheduler runs.
   always_comb begin
      for (int i = 0; i < N_PORTS; i++) begin
         move[i]     = 1'b0;
         move_src[i] = grant_src[i];
         busy[i]     = (state[i] == LOCKED);
         if (xfer_phase) begin
            case (state[i])
               IDLE: begin
                  if (pick_valid[i]) begin
                     move[i]     = 1'b1;
                     move_src[i] = pick_src[i];
                  end
               end
               LOCKED: begin
                  if (in_rd_add[grant_src[i]][i] != in_wr_add[grant_src[i]][i]) begin
                     move[i] = 1'b1;
                  end
               end
               default: begin
                  move[i] = 1'b0;
               end
            endcase
         end
         move_word[i] = inp[move_src[i]][i];
      end
      for (int j = 0; j < N_PORTS; j++) begin
         for (int i = 0; i < N_PORTS; i++) begin
            in_rden[j][i] = enable && !reset;
         end
      end
   end

   // FSM next-state logic. Moving a non-zero word leaves the machine in
   // LOCKED, which also covers the grant taken from IDLE. Moving the zero
   // delimiter releases the output, and the next transfer phase runs a
   // new arbitration.
   always_comb begin
      for (int i = 0; i < N_PORTS; i++) begin
         state_next[i] = state[i];
         if (move[i]) begin
            if (move_word[i] == '0) begin
               state_next[i] = IDLE;
            end else begin
               state_next[i] = LOCKED;
            end
         end
      end
   end

   // Datapath registers for each output.
   // - On a move: capture the word, pulse out_wr for one cycle, record the
   //   serving source, and advance that source's read pointer. The pointer
   //   wraps naturally at 2^ADDR_W.
   // - Otherwise: drop the strobe and hold outp.
   // Reset puts grant_src at the last source, so source 0 is scanned
   // first after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_PORTS; i++) begin
            outp[i]      <= '0;
            out_wr[i]    <= 1'b0;
            grant_src[i] <= SRC_W'(N_PORTS - 1);
            for (int j = 0; j < N_PORTS; j++) begin
               in_rd_add[j][i] <= '0;
            end
         end
      end else begin
         for (int i = 0; i < N_PORTS; i++) begin
            out_wr[i] <= 1'b0;
            if (move[i]) begin
               outp[i]                   <= move_word[i];
               out_wr[i]                 <= 1'b1;
               grant_src[i]              <= move_src[i];
               in_rd_add[move_src[i]][i] <= in_rd_add[move_src[i]][i] + ADDR_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_rr_scheduler
//
// Directed bench for rr_scheduler with 4 ports, 32-bit words and 4-bit
// RAM addresses. The narrow addresses let the bench reach read-pointer
// wrap-around quickly.
//
// Each input RAM is modelled as a 16-entry array. The array is read
// combinationally at the DUT's read pointer.
// ---------------------------------------------------------------------------
module tb_rr_scheduler;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AW = 4;
   localparam int RW = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          enable = 1'b0;
   logic [DW-1:0] inp        [N][N];
   logic [AW-1:0] in_wr_add  [N][N];
   logic [AW-1:0] in_rd_add  [N][N];
   logic          in_rden    [N][N];
   logic [DW-1:0] outp       [N];
   logic          out_wr     [N];
   logic          busy       [N];
   logic [1:0]    grant_src  [N];
   logic [31:0]   total_time;

   logic [DW-1:0] mem [N][N][16];

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic        en;
      logic        wr;
      logic [31:0] data;
      logic        bsy;
      logic [3:0]  rd;
      logic [1:0]  gnt;
      logic [31:0] tt;
   } vec_t;

   vec_t vecs [14];

   logic [31:0] rr_word [8];
   logic [1:0]  rr_src  [8];

   rr_scheduler #(
      .N_PORTS   (N),
      .DATA_W    (DW),
      .ADDR_W    (AW),
      .READ_WAIT (RW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .inp        (inp),
      .in_wr_add  (in_wr_add),
      .in_rd_add  (in_rd_add),
      .in_rden    (in_rden),
      .outp       (outp),
      .out_wr     (out_wr),
      .busy       (busy),
      .grant_src  (grant_src),
      .total_time (total_time)
   );

   always #5 clk = ~clk;

   // Input RAM model: the read data follows the DUT's read pointer.
   for (genvar j = 0; j < N; j++) begin : g_src
      for (genvar i = 0; i < N; i++) begin : g_dst
         assign inp[j][i] = mem[j][i][in_rd_add[j][i]];
      end
   end

   // Compares one value and reports any difference.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drives enable, waits one rising edge, then settles just past it.
   task automatic applyStimulus(input logic en);
      enable = en;
      @(posedge clk);
      #1;
   endtask

   // Empties every RAM and write pointer.
   task automatic clearRams();
      for (int j = 0; j < N; j++) begin
         for (int i = 0; i < N; i++) begin
            in_wr_add[j][i] = '0;
            for (int a = 0; a < 16; a++) begin
               mem[j][i][a] = '0;
            end
         end
      end
   endtask

   // Pulses reset across one clock edge, with empty RAMs.
   task automatic doReset();
      enable = 1'b0;
      reset  = 1'b1;
      clearRams();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      int pulses;

      // Single-packet trace on output 2 from source 1, one row per clock
      // edge: {enable, out_wr, outp, busy, rd_add[1][2], grant_src, total_time}.
      vecs[0]  = '{1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 2'd3, 32'd1};
      vecs[1]  = '{1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 2'd3, 32'd2};
      vecs[2]  = '{1'b1, 1'b1, 32'd5, 1'b1, 4'd1, 2'd1, 32'd3};
      vecs[3]  = '{1'b1, 1'b0, 32'd5, 1'b1, 4'd1, 2'd1, 32'd4};
      vecs[4]  = '{1'b0, 1'b0, 32'd5, 1'b1, 4'd1, 2'd1, 32'd4};
      vecs[5]  = '{1'b0, 1'b0, 32'd5, 1'b1, 4'd1, 2'd1, 32'd4};
      vecs[6]  = '{1'b1, 1'b0, 32'd5, 1'b1, 4'd1, 2'd1, 32'd5};
      vecs[7]  = '{1'b1, 1'b1, 32'd6, 1'b1, 4'd2, 2'd1, 32'd6};
      vecs[8]  = '{1'b1, 1'b0, 32'd6, 1'b1, 4'd2, 2'd1, 32'd7};
      vecs[9]  = '{1'b1, 1'b0, 32'd6, 1'b1, 4'd2, 2'd1, 32'd8};
      vecs[10] = '{1'b1, 1'b1, 32'd0, 1'b0, 4'd3, 2'd1, 32'd9};
      vecs[11] = '{1'b1, 1'b0, 32'd0, 1'b0, 4'd3, 2'd1, 32'd9};
      vecs[12] = '{1'b1, 1'b0, 32'd0, 1'b0, 4'd3, 2'd1, 32'd9};
      vecs[13] = '{1'b1, 1'b0, 32'd0, 1'b0, 4'd3, 2'd1, 32'd9};

      // Output 0 order: source 0 packet, source 3 packet, source 0 packet.
      rr_word = '{32'hA1, 32'hA2, 32'h0, 32'hC1, 32'hC2, 32'h0, 32'hB1, 32'h0};
      rr_src  = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};

      clearRams();
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Reset state.
      for (int i = 0; i < N; i++) begin
         checkOutput($sformatf("reset.out_wr[%0d]", i), 32'(out_wr[i]), 32'd0);
         checkOutput($sformatf("reset.busy[%0d]", i), 32'(busy[i]), 32'd0);
         checkOutput($sformatf("reset.outp[%0d]", i), outp[i], 32'd0);
         checkOutput($sformatf("reset.grant_src[%0d]", i), 32'(grant_src[i]), 32'd3);
         for (int j = 0; j < N; j++) begin
            checkOutput($sformatf("reset.in_rd_add[%0d][%0d]", j, i), 32'(in_rd_add[j][i]), 32'd0);
         end
      end
      checkOutput("reset.total_time", total_time, 32'd0);

      // Single packet 5,6,0 from source 1 to output 2.
      mem[1][2][0] = 32'd5;
      mem[1][2][1] = 32'd6;
      mem[1][2][2] = 32'd0;
      in_wr_add[1][2] = 4'd3;
      enable = 1'b1;
      #1;
      checkOutput("reset.in_rden", 32'(in_rden[1][2]), 32'd0);
      reset = 1'b0;
      #1;
      checkOutput("run.in_rden", 32'(in_rden[1][2]), 32'd1);

      for (int v = 0; v < 14; v++) begin
         applyStimulus(vecs[v].en);
         checkOutput($sformatf("pkt[%0d].out_wr", v), 32'(out_wr[2]), 32'(vecs[v].wr));
         checkOutput($sformatf("pkt[%0d].outp", v), outp[2], vecs[v].data);
         checkOutput($sformatf("pkt[%0d].busy", v), 32'(busy[2]), 32'(vecs[v].bsy));
         checkOutput($sformatf("pkt[%0d].rd_add", v), 32'(in_rd_add[1][2]), 32'(vecs[v].rd));
         checkOutput($sformatf("pkt[%0d].grant", v), 32'(grant_src[2]), 32'(vecs[v].gnt));
         checkOutput($sformatf("pkt[%0d].total_time", v), total_time, vecs[v].tt);
      end

      // total_time accounting and freezing with enable low.
      // - A zero head word in RAM[2][1] stays pending forever without being
      //   granted.
      // - RAM[0][0] has a packet whose delimiter would go out during the
      //   enable-low window if enable were ignored.
      doReset();
      in_wr_add[2][1] = 4'd1;
      mem[0][0][0] = 32'h9;
      mem[0][0][1] = 32'h8;
      mem[0][0][2] = 32'h7;
      mem[0][0][3] = 32'h0;
      in_wr_add[0][0] = 4'd4;
      for (int c = 0; c < 10; c++) begin
         applyStimulus(1'b1);
      end
      checkOutput("tt.after10", total_time, 32'd10);
      checkOutput("tt.zero_head_grant", 32'(grant_src[1]), 32'd3);
      checkOutput("tt.zero_head_rd", 32'(in_rd_add[2][1]), 32'd0);
      checkOutput("tt.word7", outp[0], 32'h7);
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1'b0);
         checkOutput($sformatf("hold[%0d].out_wr", c), 32'(out_wr[0]), 32'd0);
      end
      checkOutput("hold.total_time", total_time, 32'd10);
      checkOutput("hold.rd_add", 32'(in_rd_add[0][0]), 32'd3);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      checkOutput("resume.out_wr", 32'(out_wr[0]), 32'd1);
      checkOutput("resume.outp", outp[0], 32'h0);
      checkOutput("resume.busy", 32'(busy[0]), 32'd0);

      // Round-robin on output 0 between sources 0 and 3. Output 1 runs
      // alongside it and moves its first word in the same cycle.
      doReset();
      mem[0][0][0] = 32'hA1;
      mem[0][0][1] = 32'hA2;
      mem[0][0][2] = 32'h0;
      mem[0][0][3] = 32'hB1;
      mem[0][0][4] = 32'h0;
      in_wr_add[0][0] = 4'd5;
      mem[3][0][0] = 32'hC1;
      mem[3][0][1] = 32'hC2;
      mem[3][0][2] = 32'h0;
      in_wr_add[3][0] = 4'd3;
      mem[2][1][0] = 32'h77;
      mem[2][1][1] = 32'h0;
      in_wr_add[2][1] = 4'd2;
      pulses = 0;
      for (int c = 0; c < 60; c++) begin
         applyStimulus(1'b1);
         if (out_wr[0]) begin
            if (pulses < 8) begin
               checkOutput($sformatf("rr[%0d].word", pulses), outp[0], rr_word[pulses]);
               checkOutput($sformatf("rr[%0d].src", pulses), 32'(grant_src[0]), 32'(rr_src[pulses]));
            end
            if (pulses == 0) begin
               checkOutput("rr.parallel_wr", 32'(out_wr[1]), 32'd1);
               checkOutput("rr.parallel_word", outp[1], 32'h77);
            end
            pulses++;
         end
      end
      checkOutput("rr.pulse_count", 32'(pulses), 32'd8);

      // Underflow stall: source 2 to output 3 runs dry at rd_add == wr_add == 2.
      doReset();
      mem[2][3][0] = 32'h11;
      mem[2][3][1] = 32'h22;
      mem[2][3][2] = 32'h33;
      mem[2][3][3] = 32'h0;
      in_wr_add[2][3] = 4'd2;
      for (int c = 0; c < 6; c++) begin
         applyStimulus(1'b1);
      end
      checkOutput("stall.outp", outp[3], 32'h22);
      checkOutput("stall.rd_add", 32'(in_rd_add[2][3]), 32'd2);
      for (int c = 0; c < 6; c++) begin
         applyStimulus(1'b1);
         checkOutput($sformatf("stall[%0d].out_wr", c), 32'(out_wr[3]), 32'd0);
      end
      checkOutput("stall.busy", 32'(busy[3]), 32'd1);
      in_wr_add[2][3] = 4'd3;
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      checkOutput("unstall.early", 32'(out_wr[3]), 32'd0);
      applyStimulus(1'b1);
      checkOutput("unstall.out_wr", 32'(out_wr[3]), 32'd1);
      checkOutput("unstall.outp", outp[3], 32'h33);
      checkOutput("unstall.rd_add", 32'(in_rd_add[2][3]), 32'd3);

      // Wrap-around: a 16-word packet whose delimiter sits at address 15.
      // The delimiter is released by moving wr_add from 15 to 0.
      doReset();
      for (int k = 0; k < 15; k++) begin
         mem[0][3][k] = 32'h100 + 32'(k);
      end
      mem[0][3][15] = 32'h0;
      in_wr_add[0][3] = 4'd15;
      for (int k = 0; k < 15; k++) begin
         applyStimulus(1'b1);
         applyStimulus(1'b1);
         applyStimulus(1'b1);
         checkOutput($sformatf("wrap[%0d].out_wr", k), 32'(out_wr[3]), 32'd1);
         checkOutput($sformatf("wrap[%0d].outp", k), outp[3], 32'h100 + 32'(k));
      end
      checkOutput("wrap.rd15", 32'(in_rd_add[0][3]), 32'd15);
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b1);
         checkOutput($sformatf("wrap.dry[%0d]", c), 32'(out_wr[3]), 32'd0);
      end
      in_wr_add[0][3] = 4'd0;
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      checkOutput("wrap.eop_wr", 32'(out_wr[3]), 32'd1);
      checkOutput("wrap.eop_word", outp[3], 32'h0);
      checkOutput("wrap.rd0", 32'(in_rd_add[0][3]), 32'd0);
      checkOutput("wrap.busy", 32'(busy[3]), 32'd0);

      // Reset mid-packet, after the 2nd of 4 words. The RAM writer resets
      // along with the scheduler.
      doReset();
      mem[1][1][0] = 32'h51;
      mem[1][1][1] = 32'h52;
      mem[1][1][2] = 32'h53;
      mem[1][1][3] = 32'h0;
      in_wr_add[1][1] = 4'd4;
      for (int c = 0; c < 6; c++) begin
         applyStimulus(1'b1);
      end
      checkOutput("midrst.pre_outp", outp[1], 32'h52);
      checkOutput("midrst.pre_wr", 32'(out_wr[1]), 32'd1);
      #2;
      reset = 1'b1;
      clearRams();
      #1;
      checkOutput("midrst.outp", outp[1], 32'h0);
      checkOutput("midrst.out_wr", 32'(out_wr[1]), 32'd0);
      checkOutput("midrst.busy", 32'(busy[1]), 32'd0);
      checkOutput("midrst.grant", 32'(grant_src[1]), 32'd3);
      checkOutput("midrst.rd_add", 32'(in_rd_add[1][1]), 32'd0);
      checkOutput("midrst.in_rden", 32'(in_rden[1][1]), 32'd0);
      checkOutput("midrst.total_time", total_time, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      pulses = 0;
      for (int c = 0; c < 12; c++) begin
         applyStimulus(1'b1);
         if (out_wr[1]) begin
            pulses++;
         end
      end
      checkOutput("midrst.no_resume", 32'(pulses), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
